// File: rtl/reg_file_if.sv
// reg_file_if: datapath-side bus of the register file (read/write addresses, enables, data).
// Ports (signals): rs1/rs2 read addresses, readOut1/readOut2 registered read data,
// rd/dataIn write address and data, readEn/writeEn per-direction enables, en global enable.
// master: decode/execute side driving addresses and consuming read data; slave: the register file.
interface reg_file_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) ();
    logic [ADDR_WIDTH-1:0] rs1;
    logic [ADDR_WIDTH-1:0] rs2;
    logic [ADDR_WIDTH-1:0] rd;
    logic [DATA_WIDTH-1:0] dataIn;
    logic [DATA_WIDTH-1:0] readOut1;
    logic [DATA_WIDTH-1:0] readOut2;
    logic                  readEn;
    logic                  writeEn;
    logic                  en;

    modport master (
        output rs1, rs2, rd, dataIn, readEn, writeEn, en,
        input  readOut1, readOut2
    );

    modport slave (
        input  rs1, rs2, rd, dataIn, readEn, writeEn, en,
        output readOut1, readOut2
    );
endinterface

// File: rtl/reg_file.sv
// reg_file: 2^ADDR_WIDTH x DATA_WIDTH register file, two registered read ports, one write port, x0 hardwired to zero.
// Ports: clk (rising edge), reset (asynchronous active-high, clears storage and read outputs),
// bus (reg_file_if.slave: rs1/rs2 -> readOut1/readOut2, rd/dataIn write, readEn/writeEn/en enables).
// Build option: define REGFILE_BYPASS_EN for write-first behaviour on a same-cycle read/write
// collision; left undefined, a colliding read returns the old stored value (read-first).
module reg_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input logic       clk,
    input logic       reset,
    reg_file_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [DATA_WIDTH-1:0] read_out1_q, read_out1_d;
    logic [DATA_WIDTH-1:0] read_out2_q, read_out2_d;
    logic [DATA_WIDTH-1:0] rdata1, rdata2;
    logic                  wr_act, rd_act;

    always_comb begin
        // Address 0 is never written, so mem_q[0] stays at its reset value of zero.
        wr_act = bus.en & bus.writeEn & (bus.rd != '0);
        rd_act = bus.en & bus.readEn;
`ifdef REGFILE_BYPASS_EN
        rdata1 = (wr_act && bus.rs1 == bus.rd) ? bus.dataIn : mem_q[bus.rs1];
        rdata2 = (wr_act && bus.rs2 == bus.rd) ? bus.dataIn : mem_q[bus.rs2];
`else
        rdata1 = mem_q[bus.rs1];
        rdata2 = mem_q[bus.rs2];
`endif
        mem_d = mem_q;
        if (wr_act)
            mem_d[bus.rd] = bus.dataIn;
        read_out1_d = rd_act ? rdata1 : read_out1_q;
        read_out2_d = rd_act ? rdata2 : read_out2_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++)
                mem_q[i] <= '0;
            read_out1_q <= '0;
            read_out2_q <= '0;
        end else begin
            mem_q       <= mem_d;
            read_out1_q <= read_out1_d;
            read_out2_q <= read_out2_d;
        end
    end

    assign bus.readOut1 = read_out1_q;
    assign bus.readOut2 = read_out2_q;
endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: scoreboard bench for reg_file; stimulus queues expected read data, a negedge monitor checks it.
module tb_reg_file;
    typedef struct {
        int          tag;
        logic [31:0] e1;
        logic [31:0] e2;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    exp_t sbq[$];

    reg_file_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();

    reg_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] e1, input logic [31:0] e2);
        n_chk++;
        if (bus.readOut1 !== e1 || bus.readOut2 !== e2) begin
            n_fail++;
            $display("FAIL %s: got readOut1=%h readOut2=%h, want %h %h", nm, bus.readOut1, bus.readOut2, e1, e2);
        end
    endtask

    // Monitor: each expectation is tagged with the cycle after the edge that samples it.
    always @(negedge clk) begin
        while (sbq.size() > 0 && sbq[0].tag <= cyc) begin
            exp_t e;
            e = sbq.pop_front();
            if (e.tag < cyc) begin
                n_chk++;
                n_fail++;
                $display("FAIL %s: expectation for cycle %0d missed at cycle %0d", e.name, e.tag, cyc);
            end else
                check(e.name, e.e1, e.e2);
        end
    end

    task automatic step(input logic e, input logic we, input logic re,
                        input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] w,
                        input logic [31:0] d, input logic chk,
                        input logic [31:0] x1, input logic [31:0] x2, input string nm);
        @(negedge clk);
        #1;
        bus.en = e; bus.writeEn = we; bus.readEn = re;
        bus.rs1 = a1; bus.rs2 = a2; bus.rd = w; bus.dataIn = d;
        if (chk) sbq.push_back('{cyc + 1, x1, x2, nm});
    endtask

    task automatic wr(input logic [4:0] w, input logic [31:0] d);
        step(1, 1, 0, 0, 0, w, d, 0, 0, 0, "");
    endtask

    task automatic rdchk(input logic [4:0] a1, input logic [4:0] a2,
                         input logic [31:0] x1, input logic [31:0] x2, input string nm);
        step(1, 0, 1, a1, a2, 0, 0, 1, x1, x2, nm);
    endtask

    initial begin
        bus.en = 0; bus.writeEn = 0; bus.readEn = 0;
        bus.rs1 = 0; bus.rs2 = 0; bus.rd = 0; bus.dataIn = 0;
        repeat (2) @(negedge clk);
        check("reset_state", 32'h0, 32'h0);
        #1 reset = 1'b0;

        wr(5, 32'hDEADBEEF);
        rdchk(5, 0, 32'hDEADBEEF, 32'h0, "pre_reset_read");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, "");
        @(negedge clk);
        #1 reset = 1'b1;
        #1 check("async_reset_no_edge", 32'h0, 32'h0);
        @(negedge clk);
        #1 reset = 1'b0;
        rdchk(5, 0, 32'h0, 32'h0, "reset_cleared_x5");

        for (int k = 1; k < 32; k++)
            wr(5'(k), k * 32'h01010101);
        for (int k = 1; k < 32; k++)
            rdchk(5'(k), 5'(k - 1), k * 32'h01010101, (k - 1) * 32'h01010101, $sformatf("sweep_%0d", k));

        wr(0, 32'hFFFFFFFF);
        rdchk(0, 1, 32'h0, 32'h01010101, "x0_protect");

        wr(3, 32'hAAAA5555);
        step(1, 0, 0, 0, 0, 3, 32'h12345678, 0, 0, 0, "");
        rdchk(3, 3, 32'hAAAA5555, 32'hAAAA5555, "writeen_off");
        rdchk(3, 5, 32'hAAAA5555, 32'h05050505, "read_before_hold");
        step(1, 0, 0, 4, 6, 0, 0, 1, 32'hAAAA5555, 32'h05050505, "readen_off_hold");
        step(0, 1, 1, 6, 7, 4, 32'hBADBAD00, 1, 32'hAAAA5555, 32'h05050505, "en_off_hold");
        rdchk(4, 6, 32'h04040404, 32'h06060606, "en_off_no_write");

        wr(7, 32'h11111111);
`ifdef REGFILE_BYPASS_EN
        step(1, 1, 1, 7, 7, 7, 32'h22222222, 1, 32'h22222222, 32'h22222222, "collision");
`else
        step(1, 1, 1, 7, 7, 7, 32'h22222222, 1, 32'h11111111, 32'h11111111, "collision");
`endif
        rdchk(7, 7, 32'h22222222, 32'h22222222, "collision_after");

        rdchk(9, 8, 32'h09090909, 32'h08080808, "x9_before_reset");
        step(1, 1, 0, 0, 0, 9, 32'hCAFEF00D, 0, 0, 0, "");
        #1 reset = 1'b1;
        @(negedge clk);
        #1 reset = 1'b0;
        bus.writeEn = 0;
        rdchk(9, 8, 32'h0, 32'h0, "mid_op_reset");

        repeat (3) @(negedge clk);
        #1;
        n_chk++;
        if (sbq.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, want 0", sbq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
